lmsm_block_sequencer: RTL and testbench

- Parametrised multi-register load/store micro-sequencer; successor to the fixed 8-iteration, counter-driven LM/SM loop in the multicycle controller.
- The main controller hands over one LM/SM instruction (register mask, base address, direction) and stalls on `busy`.
- The block walks only the set mask bits, runs one memory handshake per register and writes register-file entries back for loads.
- Sits between the controller, register file and memory port; the datapath muxes give it those ports while `busy`=1.

---
 rtl/lmsm_pkg.sv | 16 +
 rtl/lmsm_prio_enc.sv | 28 ++
 rtl/lmsm_block_sequencer.sv | 165 ++++++++++++++++
 tb/tb_lmsm_block_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// Shared types and default sizes for the LM/SM block sequencer.
// Optional feature macro: LMSM_DESC_EN (descending / stack-order transfers).
package lmsm_pkg;

   localparam int LMSM_NREG   = 8;
   localparam int LMSM_DATA_W = 16;
   localparam int LMSM_ADDR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_WB   = 2'd2,
      ST_DONE = 2'd3
   } lmsm_state_e;

endpackage

// File: rtl/lmsm_prio_enc.sv
// Priority encoder over the pending register mask.
// dir=0 picks the lowest set bit, dir=1 the highest (dir only driven
// non-zero when LMSM_DESC_EN is defined).
module lmsm_prio_enc
   import lmsm_pkg::*;
#(
   parameter  int NREG  = LMSM_NREG,
   localparam int IDX_W = $clog2(NREG)
) (
   input  logic [NREG-1:0]  mask,
   input  logic             dir,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Ascending scan: the first hit wins for dir=0, the last hit wins for dir=1.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (mask[i] && (dir || !any)) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lmsm_block_sequencer.sv
// Multi-register load/store micro-sequencer. Walks the set bits of the
// latched register mask, runs one memory handshake per register and, for
// loads, writes the returned data back through a one-cycle WB state.
// All flops update on the falling clock edge, matching the controller.
// Optional feature macro: LMSM_DESC_EN adds the `desc` input
// (highest register first, addresses counting down from base).
module lmsm_block_sequencer
   import lmsm_pkg::*;
#(
   parameter  int NREG   = LMSM_NREG,
   parameter  int DATA_W = LMSM_DATA_W,
   parameter  int ADDR_W = LMSM_ADDR_W,
   localparam int IDX_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [NREG-1:0]   reg_mask,
   input  logic [ADDR_W-1:0] base_addr,
`ifdef LMSM_DESC_EN
   input  logic              desc,
`endif
   output logic              busy,
   output logic              done,
   output logic [IDX_W:0]    xfer_count,
   output logic [IDX_W-1:0]  rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_wen,
   output logic [IDX_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   lmsm_state_e       state_q, state_n;
   logic [NREG-1:0]   mask_q, mask_n, clr_bit;
   logic [ADDR_W-1:0] base_q, base_n, off_q, off_n, addr_n;
   logic              store_q, store_n, dir_q, dir_n;
   logic [IDX_W:0]    cnt_n;
   logic [IDX_W-1:0]  idx_q, enc_idx, waddr_n;
   logic [DATA_W-1:0] wdata_n;
   logic              enc_any, desc_in;

`ifdef LMSM_DESC_EN
   assign desc_in = desc;
`else
   assign desc_in = 1'b0;
`endif

   // The encoder looks at the *next* pending mask so the current index can
   // be registered alongside the state; rf_raddr is then a plain flop.
   lmsm_prio_enc #(.NREG(NREG)) u_prio_enc (
      .mask (mask_n),
      .dir  (dir_n),
      .idx  (enc_idx),
      .any  (enc_any)
   );

   assign rf_raddr  = idx_q;
   assign mem_wdata = mem_req ? rf_rdata : '0;

   // Next pending mask and direction (kept apart from the FSM to avoid a loop through the encoder).
   always_comb begin
      mask_n  = mask_q;
      dir_n   = dir_q;
      clr_bit = '0;
      clr_bit[idx_q] = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_n = reg_mask;
               dir_n  = desc_in;
            end
         end
         ST_XFER: begin
            if (mem_ack) mask_n = mask_q & ~clr_bit;
         end
         default: ;
      endcase
   end

   // FSM next state, offset/count bookkeeping and load capture.
   always_comb begin
      state_n = state_q;
      base_n  = base_q;
      off_n   = off_q;
      store_n = store_q;
      cnt_n   = xfer_count;
      waddr_n = rf_waddr;
      wdata_n = rf_wdata;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_n  = base_addr;
               store_n = is_store;
               off_n   = '0;
               cnt_n   = '0;
               state_n = enc_any ? ST_XFER : ST_DONE;
            end
         end
         ST_XFER: begin
            if (mem_ack) begin
               off_n = off_q + ADDR_W'(1);
               cnt_n = xfer_count + (IDX_W+1)'(1);
               if (!store_q) begin
                  wdata_n = mem_rdata;
                  waddr_n = idx_q;
                  state_n = ST_WB;
               end else begin
                  state_n = enc_any ? ST_XFER : ST_DONE;
               end
            end
         end
         ST_WB:   state_n = enc_any ? ST_XFER : ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      addr_n = dir_n ? (base_n - off_n) : (base_n + off_n);
   end

   // State and registered outputs; outputs are decoded from the next state so they align with it.
   always_ff @(negedge clk) begin
      if (!proc_rst) begin
         state_q    <= ST_IDLE;
         mask_q     <= '0;
         base_q     <= '0;
         off_q      <= '0;
         store_q    <= 1'b0;
         dir_q      <= 1'b0;
         idx_q      <= '0;
         xfer_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state_q    <= state_n;
         mask_q     <= mask_n;
         base_q     <= base_n;
         off_q      <= off_n;
         store_q    <= store_n;
         dir_q      <= dir_n;
         idx_q      <= enc_idx;
         xfer_count <= cnt_n;
         busy       <= (state_n != ST_IDLE);
         done       <= (state_n == ST_DONE);
         rf_wen     <= (state_n == ST_WB);
         rf_waddr   <= waddr_n;
         rf_wdata   <= wdata_n;
         mem_req    <= (state_n == ST_XFER);
         mem_we     <= (state_n == ST_XFER) && store_n;
         mem_addr   <= (state_n == ST_XFER) ? addr_n : '0;
      end
   end

endmodule

// File: tb/tb_lmsm_block_sequencer.sv
// Directed bench for lmsm_block_sequencer with a behavioural register file
// and a memory that acks after a programmable number of wait cycles.
// DUT flops move on negedge; the bench samples and drives on posedge.
// Build with LMSM_DESC_EN defined to exercise the descending mode.
module tb_lmsm_block_sequencer;

   logic        clk = 1'b0;
   logic        proc_rst;
   logic        start;
   logic        is_store;
   logic [7:0]  reg_mask;
   logic [15:0] base_addr;
   logic        busy, done;
   logic [3:0]  xfer_count;
   logic [2:0]  rf_raddr, rf_waddr;
   logic [15:0] rf_rdata, rf_wdata;
   logic        rf_wen;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef LMSM_DESC_EN
   logic        desc;
`endif

   logic [15:0] rf  [0:7];
   logic [15:0] mem [0:65535];
   int          ack_delay;
   int          wait_cnt;
   logic [15:0] ack_addr_q [$];
   logic [15:0] wr_data_q  [$];

   int checks   = 0;
   int failures = 0;

   int         r_done_n, r_busy, r_req, r_wen, r_wen_run, r_stab;
   logic       r_post_busy, r_post_done;
   logic [3:0] r_post_cnt;

   lmsm_block_sequencer #(.NREG(8), .DATA_W(16), .ADDR_W(16)) dut (
      .clk        (clk),
      .proc_rst   (proc_rst),
      .start      (start),
      .is_store   (is_store),
      .reg_mask   (reg_mask),
      .base_addr  (base_addr),
`ifdef LMSM_DESC_EN
      .desc       (desc),
`endif
      .busy       (busy),
      .done       (done),
      .xfer_count (xfer_count),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   assign rf_rdata  = rf[rf_raddr];
   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

   // Memory / register-file models update on the DUT's active edge.
   always @(negedge clk) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
      if (proc_rst && mem_req && mem_ack) begin
         ack_addr_q.push_back(mem_addr);
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_data_q.push_back(mem_wdata);
         end
      end
      if (proc_rst && rf_wen) rf[rf_waddr] <= rf_wdata;
   end

   // Launch one operation and observe it until done (bounded), then one more cycle.
   task automatic run_op(input logic st, input logic [7:0] m, input logic [15:0] b,
                         input int dly, input logic dsc, input logic restart_pulse);
      logic        prev_wait;
      logic [15:0] prev_addr;
      logic        prev_we;
      logic [2:0]  prev_ra;
      int          run;
      ack_delay = dly;
      ack_addr_q.delete();
      wr_data_q.delete();
      r_done_n = -1; r_busy = 0; r_req = 0; r_wen = 0; r_wen_run = 0; r_stab = 0;
      run = 0; prev_wait = 1'b0; prev_addr = '0; prev_we = 1'b0; prev_ra = '0;
      is_store = st; reg_mask = m; base_addr = b;
`ifdef LMSM_DESC_EN
      desc = dsc;
`else
      if (dsc) $display("note: desc ignored in this build");
`endif
      start = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         start = restart_pulse && (n == 2);
         if (busy)    r_busy++;
         if (mem_req) r_req++;
         if (rf_wen) begin
            r_wen++; run++;
            if (run > r_wen_run) r_wen_run = run;
         end else run = 0;
         if (prev_wait && mem_req &&
             (mem_addr !== prev_addr || mem_we !== prev_we || rf_raddr !== prev_ra)) r_stab++;
         prev_wait = mem_req && !mem_ack;
         prev_addr = mem_addr; prev_we = mem_we; prev_ra = rf_raddr;
         if (done) begin
            r_done_n = n;
            break;
         end
      end
      start = 1'b0;
      @(posedge clk);
      r_post_busy = busy; r_post_done = done; r_post_cnt = xfer_count;
   endtask

   task automatic test_reset();
      proc_rst = 1'b0; start = 1'b0; is_store = 1'b0; reg_mask = '0; base_addr = '0;
      repeat (3) @(posedge clk);
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)      begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (mem_req !== 1'b0)   begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
      checks++; if (rf_wen !== 1'b0)    begin failures++; $display("FAIL rst_rf_wen got=%b exp=0", rf_wen); end
      checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
      checks++; if (xfer_count !== 4'd0) begin failures++; $display("FAIL rst_xfer_count got=%0d exp=0", xfer_count); end
      checks++; if (rf_raddr !== 3'd0)  begin failures++; $display("FAIL rst_rf_raddr got=%0d exp=0", rf_raddr); end
      checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0000", mem_wdata); end
      proc_rst = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_sm();
      logic [15:0] ea [4];
      logic [15:0] ed [4];
      ea = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
      ed = '{16'd11, 16'd22, 16'd55, 16'd77};
      rf[0] = 16'd11; rf[2] = 16'd22; rf[5] = 16'd55; rf[7] = 16'd77;
      rf[1] = 16'hDEAD; rf[3] = 16'hDEAD; rf[4] = 16'hDEAD; rf[6] = 16'hDEAD;
      run_op(1'b1, 8'b1010_0101, 16'h0100, 0, 1'b0, 1'b0);
      checks++; if (r_done_n !== 5) begin failures++; $display("FAIL sm_done_cycle got=%0d exp=5", r_done_n); end
      checks++; if (r_post_cnt !== 4'd4) begin failures++; $display("FAIL sm_xfer_count got=%0d exp=4", r_post_cnt); end
      checks++; if (r_post_done !== 1'b0) begin failures++; $display("FAIL sm_done_width got=%b exp=0", r_post_done); end
      checks++; if (r_post_busy !== 1'b0) begin failures++; $display("FAIL sm_busy_after got=%b exp=0", r_post_busy); end
      checks++; if (wr_data_q.size() !== 4) begin failures++; $display("FAIL sm_write_count got=%0d exp=4", wr_data_q.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
               failures++;
               $display("FAIL sm_write%0d got=(%h,%0d) exp=(%h,%0d)", i, ack_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
         end
      end
   endtask

   task automatic test_lm_wait();
      mem[16'h0200] = 16'hAAAA; mem[16'h0201] = 16'h5555;
      rf[0] = 16'h0; rf[7] = 16'h0; rf[3] = 16'h1234;
      run_op(1'b0, 8'h81, 16'h0200, 2, 1'b0, 1'b0);
      checks++; if (rf[0] !== 16'hAAAA) begin failures++; $display("FAIL lm_r0 got=%h exp=AAAA", rf[0]); end
      checks++; if (rf[7] !== 16'h5555) begin failures++; $display("FAIL lm_r7 got=%h exp=5555", rf[7]); end
      checks++; if (rf[3] !== 16'h1234) begin failures++; $display("FAIL lm_r3_untouched got=%h exp=1234", rf[3]); end
      checks++; if (r_wen !== 2 || r_wen_run !== 1) begin failures++; $display("FAIL lm_wen_pulses got=%0d/run%0d exp=2/run1", r_wen, r_wen_run); end
      checks++; if (r_stab !== 0) begin failures++; $display("FAIL lm_addr_stable got=%0d exp=0", r_stab); end
      checks++; if (r_done_n !== 9) begin failures++; $display("FAIL lm_done_cycle got=%0d exp=9", r_done_n); end
      checks++; if (r_post_cnt !== 4'd2) begin failures++; $display("FAIL lm_xfer_count got=%0d exp=2", r_post_cnt); end
      checks++; if (wr_data_q.size() !== 0) begin failures++; $display("FAIL lm_no_writes got=%0d exp=0", wr_data_q.size()); end
   endtask

   task automatic test_zero_mask();
      run_op(1'b1, 8'h00, 16'h0400, 0, 1'b0, 1'b0);
      checks++; if (r_done_n !== 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", r_done_n); end
      checks++; if (r_busy !== 1 || r_post_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0d/%b exp=1/0", r_busy, r_post_busy); end
      checks++; if (r_req !== 0) begin failures++; $display("FAIL zero_mem_req got=%0d exp=0", r_req); end
      checks++; if (r_post_cnt !== 4'd0) begin failures++; $display("FAIL zero_xfer_count got=%0d exp=0", r_post_cnt); end
   endtask

   task automatic test_wrap_ignore_start();
      rf[0] = 16'd11; rf[1] = 16'h1111;
      run_op(1'b1, 8'h03, 16'hFFFF, 0, 1'b0, 1'b1);
      checks++; if (ack_addr_q.size() !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", ack_addr_q.size()); end
      else begin
         checks++; if (ack_addr_q[0] !== 16'hFFFF || ack_addr_q[1] !== 16'h0000) begin
            failures++; $display("FAIL wrap_addr got=%h,%h exp=FFFF,0000", ack_addr_q[0], ack_addr_q[1]);
         end
         checks++; if (wr_data_q[0] !== 16'd11 || wr_data_q[1] !== 16'h1111) begin
            failures++; $display("FAIL wrap_data got=%h,%h exp=000b,1111", wr_data_q[0], wr_data_q[1]);
         end
      end
      checks++; if (r_done_n !== 3) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=3", r_done_n); end
      checks++; if (r_post_busy !== 1'b0) begin failures++; $display("FAIL wrap_restart_ignored got=%b exp=0", r_post_busy); end
   endtask

`ifdef LMSM_DESC_EN
   task automatic test_desc();
      rf[1] = 16'h1111; rf[2] = 16'd22;
      run_op(1'b1, 8'h06, 16'h0010, 0, 1'b1, 1'b0);
      checks++; if (ack_addr_q.size() !== 2) begin failures++; $display("FAIL desc_count got=%0d exp=2", ack_addr_q.size()); end
      else begin
         checks++; if (ack_addr_q[0] !== 16'h0010 || wr_data_q[0] !== 16'd22) begin
            failures++; $display("FAIL desc_first got=(%h,%h) exp=(0010,0016)", ack_addr_q[0], wr_data_q[0]);
         end
         checks++; if (ack_addr_q[1] !== 16'h000F || wr_data_q[1] !== 16'h1111) begin
            failures++; $display("FAIL desc_second got=(%h,%h) exp=(000f,1111)", ack_addr_q[1], wr_data_q[1]);
         end
      end
      desc = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_lm();
      int xfers;
      logic hit;
      xfers = 0; hit = 1'b0;
      ack_delay = 0;
      is_store = 1'b0; reg_mask = 8'hFF; base_addr = 16'h0500;
`ifdef LMSM_DESC_EN
      desc = 1'b0;
`endif
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (mem_req) xfers++;
         if (xfers == 3) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk);
      end
      checks++; if (hit !== 1'b1 || xfer_count !== 4'd2) begin
         failures++; $display("FAIL midrst_third_xfer got=hit%b/cnt%0d exp=hit1/cnt2", hit, xfer_count);
      end
      proc_rst = 1'b0;
      @(posedge clk);
      checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || rf_wen !== 1'b0) begin
         failures++; $display("FAIL midrst_outputs got=busy%b/req%b/wen%b exp=0/0/0", busy, mem_req, rf_wen);
      end
      checks++; if (xfer_count !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", xfer_count); end
      proc_rst = 1'b1;
      @(posedge clk);
      rf[0] = 16'h0BEE;
      run_op(1'b1, 8'h01, 16'h0300, 0, 1'b0, 1'b0);
      checks++; if (ack_addr_q.size() !== 1) begin failures++; $display("FAIL midrst_rerun_count got=%0d exp=1", ack_addr_q.size()); end
      else begin
         checks++; if (ack_addr_q[0] !== 16'h0300 || wr_data_q[0] !== 16'h0BEE) begin
            failures++; $display("FAIL midrst_rerun got=(%h,%h) exp=(0300,0bee)", ack_addr_q[0], wr_data_q[0]);
         end
      end
      checks++; if (r_done_n !== 2 || r_post_cnt !== 4'd1) begin
         failures++; $display("FAIL midrst_rerun_timing got=%0d/cnt%0d exp=2/cnt1", r_done_n, r_post_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
      for (int i = 0; i < 8; i++) rf[i] = 16'h0;
      ack_delay = 0;
`ifdef LMSM_DESC_EN
      desc = 1'b0;
`endif
      test_reset();
      test_sm();
      test_lm_wait();
      test_zero_mask();
      test_wrap_ignore_start();
`ifdef LMSM_DESC_EN
      test_desc();
`endif
      test_reset_mid_lm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
